// File: rtl/writeback_arb.sv
// writeback_arb: multi-source writeback stage for the swt16 core.
// A round-robin arbiter accepts one completed result per cycle from NUM_SRC
// valid/ready channels. The accepted result is registered onto the
// register-file write port, which also feeds the forwarding network.
// Saturating retire and stall statistics are kept alongside.
module writeback_arb #(
  parameter int NUM_SRC         = 2,
  parameter int PMEM_WORD_WIDTH = 16,
  parameter int IALU_WORD_WIDTH = 16,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int PC_WIDTH        = 12,
  parameter int CNT_WIDTH       = 16,
  parameter int DISCARD_R0      = 1
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_SRC-1:0]                   in_valid,
  output logic [NUM_SRC-1:0]                   in_ready,
  input  logic [NUM_SRC-1:0]                   in_act_write_res_to_reg,
  input  logic [NUM_SRC*IALU_WORD_WIDTH-1:0]   in_res,
  input  logic [NUM_SRC*REG_IDX_WIDTH-1:0]     in_res_reg_idx,
  input  logic [NUM_SRC*PMEM_WORD_WIDTH-1:0]   in_instr,
  input  logic [NUM_SRC*PC_WIDTH-1:0]          in_pc,
  input  logic                                 in_flush,
  output logic                                 out_act_write_res_to_reg,
  output logic [IALU_WORD_WIDTH-1:0]           out_res,
  output logic [REG_IDX_WIDTH-1:0]             out_res_reg_idx,
  output logic                                 out_retire_valid,
  output logic [PMEM_WORD_WIDTH-1:0]           out_retire_instr,
  output logic [PC_WIDTH-1:0]                  out_retire_pc,
  output logic [CNT_WIDTH-1:0]                 out_retire_cnt,
  output logic [CNT_WIDTH-1:0]                 out_stall_cnt
);

  // A single source still needs a one-bit pointer so the vectors stay legal.
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + CNT_WIDTH'(1);
    end
  endfunction

  // Number of sources offering a result this cycle.
  function automatic int unsigned popcnt(input logic [NUM_SRC-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (v[i]) begin
        n = n + 32'd1;
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // State
  logic [PTR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                       we_q, we_d;
  logic [IALU_WORD_WIDTH-1:0] res_q, res_d;
  logic [REG_IDX_WIDTH-1:0]   idx_q, idx_d;
  logic                       rvalid_q, rvalid_d;
  logic [PMEM_WORD_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]        pc_q, pc_d;
  logic [CNT_WIDTH-1:0]       rcnt_q, rcnt_d;
  logic [CNT_WIDTH-1:0]       scnt_q, scnt_d;

  // Arbitration / selection
  logic                       found_s;
  logic                       hs_s;
  logic                       stall_s;
  logic [PTR_W-1:0]           grant_idx_s;
  logic [NUM_SRC-1:0]         ready_s;
  logic                       sel_act_s;
  logic [IALU_WORD_WIDTH-1:0] sel_res_s;
  logic [REG_IDX_WIDTH-1:0]   sel_idx_s;
  logic [PMEM_WORD_WIDTH-1:0] sel_instr_s;
  logic [PC_WIDTH-1:0]        sel_pc_s;

  // Round-robin search: first valid source at or after rr_ptr, wrapping.
  always_comb begin
    found_s     = 1'b0;
    grant_idx_s = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!found_s && in_valid[(int'(rr_ptr_q) + k) % NUM_SRC]) begin
        found_s     = 1'b1;
        grant_idx_s = PTR_W'((int'(rr_ptr_q) + k) % NUM_SRC);
      end else begin
        found_s     = found_s;
      end
    end
    // Nothing is accepted while reset is held; flush does not block the grant.
    hs_s = found_s && !reset;
  end

  // One-hot ready on the granted source and an AND-OR mux of its fields.
  always_comb begin
    ready_s     = '0;
    sel_act_s   = 1'b0;
    sel_res_s   = '0;
    sel_idx_s   = '0;
    sel_instr_s = '0;
    sel_pc_s    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ready_s[i]  = hs_s && (int'(grant_idx_s) == i);
      sel_act_s   = sel_act_s | (found_s && (int'(grant_idx_s) == i) && in_act_write_res_to_reg[i]);
      sel_res_s   = sel_res_s
                  | ({IALU_WORD_WIDTH{int'(grant_idx_s) == i}} & in_res[i*IALU_WORD_WIDTH +: IALU_WORD_WIDTH]);
      sel_idx_s   = sel_idx_s
                  | ({REG_IDX_WIDTH{int'(grant_idx_s) == i}} & in_res_reg_idx[i*REG_IDX_WIDTH +: REG_IDX_WIDTH]);
      sel_instr_s = sel_instr_s
                  | ({PMEM_WORD_WIDTH{int'(grant_idx_s) == i}} & in_instr[i*PMEM_WORD_WIDTH +: PMEM_WORD_WIDTH]);
      sel_pc_s    = sel_pc_s
                  | ({PC_WIDTH{int'(grant_idx_s) == i}} & in_pc[i*PC_WIDTH +: PC_WIDTH]);
    end
  end

  assign in_ready = ready_s;

  // Next-state for the pointer, output register and statistics.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = 1'b0;
    rvalid_d = 1'b0;
    res_d    = res_q;
    idx_d    = idx_q;
    instr_d  = instr_q;
    pc_d     = pc_q;
    rcnt_d   = rcnt_q;
    scnt_d   = scnt_q;
    // A valid source waited if more sources offered than were accepted.
    stall_s  = popcnt(in_valid) > (hs_s ? 32'd1 : 32'd0);

    if (hs_s) begin
      if (int'(grant_idx_s) == NUM_SRC - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    // A flushed result is consumed but leaves the data outputs untouched.
    if (hs_s && !in_flush) begin
      rvalid_d = 1'b1;
      we_d     = sel_act_s && !((DISCARD_R0 != 0) && (sel_idx_s == '0));
      res_d    = sel_res_s;
      idx_d    = sel_idx_s;
      instr_d  = sel_instr_s;
      pc_d     = sel_pc_s;
      rcnt_d   = sat_inc(rcnt_q);
    end else begin
      rvalid_d = 1'b0;
      we_d     = 1'b0;
    end

    if (stall_s) begin
      scnt_d = sat_inc(scnt_q);
    end else begin
      scnt_d = scnt_q;
    end
  end

  // State register with synchronous reset taking priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr_q <= '0;
      we_q     <= 1'b0;
      res_q    <= '0;
      idx_q    <= '0;
      rvalid_q <= 1'b0;
      instr_q  <= '0;
      pc_q     <= '0;
      rcnt_q   <= '0;
      scnt_q   <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      rvalid_q <= rvalid_d;
      instr_q  <= instr_d;
      pc_q     <= pc_d;
      rcnt_q   <= rcnt_d;
      scnt_q   <= scnt_d;
    end
  end

  assign out_act_write_res_to_reg = we_q;
  assign out_res                  = res_q;
  assign out_res_reg_idx          = idx_q;
  assign out_retire_valid         = rvalid_q;
  assign out_retire_instr         = instr_q;
  assign out_retire_pc            = pc_q;
  assign out_retire_cnt           = rcnt_q;
  assign out_stall_cnt            = scnt_q;

endmodule

// File: tb/tb_writeback_arb.sv
// Testbench for writeback_arb: three instances share one stimulus stream
// (default, DISCARD_R0 = 0, CNT_WIDTH = 3) and are checked against a
// behavioural model of the retirement rules.
module tb_writeback_arb;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [1:0]  in_valid;
  logic [1:0]  in_act;
  logic [31:0] in_res;
  logic [7:0]  in_idx;
  logic [31:0] in_instr;
  logic [23:0] in_pc;
  logic        in_flush;

  logic [1:0]  a_rdy, b_rdy, c_rdy;
  logic        a_we, b_we, c_we;
  logic [15:0] a_res, b_res, c_res;
  logic [3:0]  a_idx, b_idx, c_idx;
  logic        a_vld, b_vld, c_vld;
  logic [15:0] a_instr, b_instr, c_instr;
  logic [11:0] a_pc, b_pc, c_pc;
  logic [15:0] a_rcnt, a_scnt, b_rcnt, b_scnt;
  logic [2:0]  c_rcnt, c_scnt;

  writeback_arb #(.NUM_SRC(2), .CNT_WIDTH(16), .DISCARD_R0(1)) dut_a (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_rdy),
    .in_act_write_res_to_reg(in_act), .in_res(in_res), .in_res_reg_idx(in_idx),
    .in_instr(in_instr), .in_pc(in_pc), .in_flush(in_flush),
    .out_act_write_res_to_reg(a_we), .out_res(a_res), .out_res_reg_idx(a_idx),
    .out_retire_valid(a_vld), .out_retire_instr(a_instr), .out_retire_pc(a_pc),
    .out_retire_cnt(a_rcnt), .out_stall_cnt(a_scnt));

  writeback_arb #(.NUM_SRC(2), .CNT_WIDTH(16), .DISCARD_R0(0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_rdy),
    .in_act_write_res_to_reg(in_act), .in_res(in_res), .in_res_reg_idx(in_idx),
    .in_instr(in_instr), .in_pc(in_pc), .in_flush(in_flush),
    .out_act_write_res_to_reg(b_we), .out_res(b_res), .out_res_reg_idx(b_idx),
    .out_retire_valid(b_vld), .out_retire_instr(b_instr), .out_retire_pc(b_pc),
    .out_retire_cnt(b_rcnt), .out_stall_cnt(b_scnt));

  writeback_arb #(.NUM_SRC(2), .CNT_WIDTH(3), .DISCARD_R0(1)) dut_c (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(c_rdy),
    .in_act_write_res_to_reg(in_act), .in_res(in_res), .in_res_reg_idx(in_idx),
    .in_instr(in_instr), .in_pc(in_pc), .in_flush(in_flush),
    .out_act_write_res_to_reg(c_we), .out_res(c_res), .out_res_reg_idx(c_idx),
    .out_retire_valid(c_vld), .out_retire_instr(c_instr), .out_retire_pc(c_pc),
    .out_retire_cnt(c_rcnt), .out_stall_cnt(c_scnt));

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  int          m_rr;
  logic        m_vld, m_we, m_we_nr0;
  logic [15:0] m_res, m_instr;
  logic [3:0]  m_idx;
  logic [11:0] m_pc;
  int          m_rcnt, m_scnt, m_rcnt3, m_scnt3;
  logic [1:0]  exp_rdy, obs_rdy, obs_rdy_b, obs_rdy_c;

  // Source that the rotating-priority rule grants now, or -1.
  function automatic int exp_grant();
    if (reset) return -1;
    for (int k = 0; k < 2; k++) begin
      if (in_valid[(m_rr + k) % 2]) return (m_rr + k) % 2;
    end
    return -1;
  endfunction

  // Sample ready before the edge, advance the model, clock, settle.
  task automatic tick();
    int g;
    int pop;
    #1;
    obs_rdy   = a_rdy;
    obs_rdy_b = b_rdy;
    obs_rdy_c = c_rdy;
    g = exp_grant();
    exp_rdy = (g < 0) ? 2'b00 : (2'b01 << g);
    if (reset) begin
      m_rr = 0; m_vld = 1'b0; m_we = 1'b0; m_we_nr0 = 1'b0;
      m_res = 16'h0; m_instr = 16'h0; m_idx = 4'h0; m_pc = 12'h0;
      m_rcnt = 0; m_scnt = 0; m_rcnt3 = 0; m_scnt3 = 0;
    end else begin
      pop = int'(in_valid[0]) + int'(in_valid[1]);
      if (pop > ((g >= 0) ? 1 : 0)) begin
        if (m_scnt < 65535) m_scnt++;
        if (m_scnt3 < 7) m_scnt3++;
      end
      if (g >= 0 && !in_flush) begin
        m_vld    = 1'b1;
        m_res    = in_res[g*16 +: 16];
        m_idx    = in_idx[g*4 +: 4];
        m_instr  = in_instr[g*16 +: 16];
        m_pc     = in_pc[g*12 +: 12];
        m_we     = in_act[g] && (in_idx[g*4 +: 4] != 4'd0);
        m_we_nr0 = in_act[g];
        if (m_rcnt < 65535) m_rcnt++;
        if (m_rcnt3 < 7) m_rcnt3++;
      end else begin
        m_vld = 1'b0; m_we = 1'b0; m_we_nr0 = 1'b0;
      end
      if (g >= 0) m_rr = (g + 1) % 2;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 2'b11; in_act = 2'b11; in_flush = 1'b0;
    in_res = 32'hBBBB_AAAA; in_idx = 8'h21; in_instr = 32'h2222_1111; in_pc = 24'h002_001;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b00) begin tests_failed++; $display("FAIL reset_ready: got %b want 00", obs_rdy); end
    tests_run++;
    if ({a_vld, a_we, a_res, a_idx, a_instr, a_pc} !== 50'd0) begin
      tests_failed++; $display("FAIL reset_outputs: vld=%b we=%b res=%h idx=%h want all 0", a_vld, a_we, a_res, a_idx);
    end
    tests_run++;
    if (a_rcnt !== 16'd0 || a_scnt !== 16'd0) begin
      tests_failed++; $display("FAIL reset_counters: rcnt=%0d scnt=%0d want 0 0", a_rcnt, a_scnt);
    end
  endtask

  task automatic test_single();
    reset = 1'b0; in_valid = 2'b01; in_act = 2'b01; in_flush = 1'b0;
    in_res[15:0] = 16'h1234; in_idx[3:0] = 4'd3; in_pc[11:0] = 12'h010; in_instr[15:0] = 16'h5A5A;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b01) begin tests_failed++; $display("FAIL single_ready: got %b want 01", obs_rdy); end
    tests_run++;
    if (a_we !== 1'b1 || a_vld !== 1'b1 || a_res !== 16'h1234 || a_idx !== 4'd3) begin
      tests_failed++; $display("FAIL single_write: we=%b vld=%b res=%h idx=%0d want 1 1 1234 3", a_we, a_vld, a_res, a_idx);
    end
    tests_run++;
    if (a_pc !== 12'h010 || a_instr !== 16'h5A5A || a_rcnt !== 16'd1) begin
      tests_failed++; $display("FAIL single_retire: pc=%h instr=%h rcnt=%0d want 010 5a5a 1", a_pc, a_instr, a_rcnt);
    end
    in_valid = 2'b00;
    tick();
    tests_run++;
    if (a_vld !== 1'b0 || a_we !== 1'b0 || a_res !== 16'h1234) begin
      tests_failed++; $display("FAIL single_idle: vld=%b we=%b res=%h want 0 0 1234", a_vld, a_we, a_res);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  want_rdy;
    logic [15:0] want_res;
    reset = 1'b1; in_valid = 2'b00; tick();
    reset = 1'b0; in_valid = 2'b11; in_act = 2'b11; in_flush = 1'b0;
    in_res = 32'hBBBB_AAAA; in_idx = 8'h21;
    for (int c = 0; c < 4; c++) begin
      want_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      want_res = (c % 2 == 0) ? 16'hAAAA : 16'hBBBB;
      tick();
      tests_run++;
      if (obs_rdy !== want_rdy || a_res !== want_res) begin
        tests_failed++; $display("FAIL rr_grant[%0d]: ready=%b res=%h want %b %h", c, obs_rdy, a_res, want_rdy, want_res);
      end
    end
    tests_run++;
    if (a_scnt !== 16'd4 || a_rcnt !== 16'd4) begin
      tests_failed++; $display("FAIL rr_counts: stall=%0d retire=%0d want 4 4", a_scnt, a_rcnt);
    end
  endtask

  task automatic test_r0();
    reset = 1'b0; in_valid = 2'b01; in_act = 2'b01; in_flush = 1'b0;
    in_idx[3:0] = 4'd0; in_res[15:0] = 16'hC0DE;
    tick();
    tests_run++;
    if (a_vld !== 1'b1 || a_we !== 1'b0) begin
      tests_failed++; $display("FAIL r0_discard: vld=%b we=%b want 1 0", a_vld, a_we);
    end
    tests_run++;
    if (b_vld !== 1'b1 || b_we !== 1'b1) begin
      tests_failed++; $display("FAIL r0_keep: vld=%b we=%b want 1 1", b_vld, b_we);
    end
  endtask

  task automatic test_flush();
    reset = 1'b1; in_valid = 2'b00; tick();
    reset = 1'b0; in_valid = 2'b01; in_act = 2'b01; in_flush = 1'b1;
    in_res[15:0] = 16'hF1F1; in_idx[3:0] = 4'd5;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b01) begin tests_failed++; $display("FAIL flush_ready: got %b want 01", obs_rdy); end
    tests_run++;
    if (a_vld !== 1'b0 || a_we !== 1'b0 || a_rcnt !== 16'd0 || a_res !== 16'h0) begin
      tests_failed++; $display("FAIL flush_out: vld=%b we=%b rcnt=%0d res=%h want 0 0 0 0000", a_vld, a_we, a_rcnt, a_res);
    end
    in_flush = 1'b0; in_valid = 2'b10;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b10) begin tests_failed++; $display("FAIL flush_ptr: ready=%b want 10", obs_rdy); end
    in_valid = 2'b00;
  endtask

  task automatic test_saturation();
    reset = 1'b1; in_valid = 2'b00; tick();
    reset = 1'b0; in_valid = 2'b01; in_act = 2'b01; in_flush = 1'b0; in_idx[3:0] = 4'd7;
    for (int c = 0; c < 9; c++) tick();
    tests_run++;
    if (c_rcnt !== 3'd7) begin tests_failed++; $display("FAIL sat_retire3: got %0d want 7", c_rcnt); end
    tests_run++;
    if (a_rcnt !== 16'd9) begin tests_failed++; $display("FAIL sat_retire16: got %0d want 9", a_rcnt); end
    in_valid = 2'b00;
  endtask

  task automatic test_reset_midstream();
    reset = 1'b0; in_valid = 2'b11; in_act = 2'b11; in_flush = 1'b0; in_idx = 8'h21;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b00) begin tests_failed++; $display("FAIL mid_reset_ready: got %b want 00", obs_rdy); end
    tests_run++;
    if ({a_vld, a_we, a_res, a_idx, a_instr, a_pc} !== 50'd0 || a_rcnt !== 16'd0 || a_scnt !== 16'd0) begin
      tests_failed++; $display("FAIL mid_reset_clear: vld=%b res=%h rcnt=%0d scnt=%0d want all 0", a_vld, a_res, a_rcnt, a_scnt);
    end
    reset = 1'b0;
    tick();
    tests_run++;
    if (obs_rdy !== 2'b01) begin tests_failed++; $display("FAIL mid_reset_first_grant: got %b want 01", obs_rdy); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < 2; i++) begin
        // A waiting source keeps its offer stable until granted.
        if (!(in_valid[i] && !obs_rdy[i])) begin
          in_valid[i]          = ($urandom_range(0, 3) != 0);
          in_act[i]            = 1'($urandom_range(0, 1));
          in_res[i*16 +: 16]   = 16'($urandom);
          in_idx[i*4 +: 4]     = 4'($urandom_range(0, 15));
          in_instr[i*16 +: 16] = 16'($urandom);
          in_pc[i*12 +: 12]    = 12'($urandom);
        end
      end
      in_flush = ($urandom_range(0, 7) == 0);
      tick();
      tests_run++;
      if (obs_rdy !== exp_rdy || obs_rdy_b !== exp_rdy || obs_rdy_c !== exp_rdy) begin
        tests_failed++; $display("FAIL rnd_ready[%0d]: got %b/%b/%b want %b", n, obs_rdy, obs_rdy_b, obs_rdy_c, exp_rdy);
      end
      tests_run++;
      if ({a_vld, a_we, a_res, a_idx, a_instr, a_pc} !== {m_vld, m_we, m_res, m_idx, m_instr, m_pc}) begin
        tests_failed++; $display("FAIL rnd_out[%0d]: vld=%b we=%b res=%h idx=%h pc=%h want %b %b %h %h %h",
                                 n, a_vld, a_we, a_res, a_idx, a_pc, m_vld, m_we, m_res, m_idx, m_pc);
      end
      tests_run++;
      if (b_we !== m_we_nr0) begin tests_failed++; $display("FAIL rnd_we_nr0[%0d]: got %b want %b", n, b_we, m_we_nr0); end
      tests_run++;
      if (a_rcnt !== 16'(m_rcnt) || a_scnt !== 16'(m_scnt) || c_rcnt !== 3'(m_rcnt3) || c_scnt !== 3'(m_scnt3)) begin
        tests_failed++; $display("FAIL rnd_cnt[%0d]: r=%0d s=%0d r3=%0d s3=%0d want %0d %0d %0d %0d",
                                 n, a_rcnt, a_scnt, c_rcnt, c_scnt, m_rcnt, m_scnt, m_rcnt3, m_scnt3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_r0();
    test_flush();
    test_saturation();
    test_reset_midstream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
